// File: rtl/sine_sample_source.sv
// Burst sample source: emits a quarter-wave-LUT sine or a constant value,
// one sample per accepted ce, for a fixed-length or continuous burst.
module sine_sample_source #(
    parameter int DATA_WIDTH  = 16,
    parameter int PHASE_WIDTH = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          ce,
    input  logic                          mode,
    input  logic [PHASE_WIDTH-1:0]        phase_inc,
    input  logic [COUNT_WIDTH-1:0]        num_samples,
    input  logic signed [DATA_WIDTH-1:0]  const_val,
    output logic signed [DATA_WIDTH-1:0]  x_out,
    output logic                          x_valid,
    output logic                          busy,
    output logic                          done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]                   state_q, state_d;
    logic [PHASE_WIDTH-1:0]       phase_q, phase_d;
    logic [COUNT_WIDTH-1:0]       count_q, count_d;
    logic [COUNT_WIDTH-1:0]       count_nxt;
    logic signed [DATA_WIDTH-1:0] x_out_q, x_out_d;
    logic                         x_valid_q, x_valid_d;
    logic                         mode_q, mode_d;
    logic [PHASE_WIDTH-1:0]       inc_q, inc_d;
    logic [COUNT_WIDTH-1:0]       num_q, num_d;
    logic signed [DATA_WIDTH-1:0] const_q, const_d;
    logic signed [DATA_WIDTH-1:0] sample;

    // First quadrant: round(32767*sin(2*pi*k/256)), k = 0..64.
    function automatic logic [14:0] quarter_lut(input logic [6:0] k);
        case (k)
            7'd0:  quarter_lut = 15'd0;     7'd1:  quarter_lut = 15'd804;
            7'd2:  quarter_lut = 15'd1608;  7'd3:  quarter_lut = 15'd2410;
            7'd4:  quarter_lut = 15'd3212;  7'd5:  quarter_lut = 15'd4011;
            7'd6:  quarter_lut = 15'd4808;  7'd7:  quarter_lut = 15'd5602;
            7'd8:  quarter_lut = 15'd6393;  7'd9:  quarter_lut = 15'd7179;
            7'd10: quarter_lut = 15'd7962;  7'd11: quarter_lut = 15'd8739;
            7'd12: quarter_lut = 15'd9512;  7'd13: quarter_lut = 15'd10278;
            7'd14: quarter_lut = 15'd11039; 7'd15: quarter_lut = 15'd11793;
            7'd16: quarter_lut = 15'd12539; 7'd17: quarter_lut = 15'd13279;
            7'd18: quarter_lut = 15'd14010; 7'd19: quarter_lut = 15'd14732;
            7'd20: quarter_lut = 15'd15446; 7'd21: quarter_lut = 15'd16151;
            7'd22: quarter_lut = 15'd16846; 7'd23: quarter_lut = 15'd17530;
            7'd24: quarter_lut = 15'd18204; 7'd25: quarter_lut = 15'd18868;
            7'd26: quarter_lut = 15'd19519; 7'd27: quarter_lut = 15'd20159;
            7'd28: quarter_lut = 15'd20787; 7'd29: quarter_lut = 15'd21403;
            7'd30: quarter_lut = 15'd22005; 7'd31: quarter_lut = 15'd22594;
            7'd32: quarter_lut = 15'd23170; 7'd33: quarter_lut = 15'd23731;
            7'd34: quarter_lut = 15'd24279; 7'd35: quarter_lut = 15'd24811;
            7'd36: quarter_lut = 15'd25329; 7'd37: quarter_lut = 15'd25832;
            7'd38: quarter_lut = 15'd26319; 7'd39: quarter_lut = 15'd26790;
            7'd40: quarter_lut = 15'd27245; 7'd41: quarter_lut = 15'd27683;
            7'd42: quarter_lut = 15'd28105; 7'd43: quarter_lut = 15'd28510;
            7'd44: quarter_lut = 15'd28898; 7'd45: quarter_lut = 15'd29268;
            7'd46: quarter_lut = 15'd29621; 7'd47: quarter_lut = 15'd29956;
            7'd48: quarter_lut = 15'd30273; 7'd49: quarter_lut = 15'd30571;
            7'd50: quarter_lut = 15'd30852; 7'd51: quarter_lut = 15'd31113;
            7'd52: quarter_lut = 15'd31356; 7'd53: quarter_lut = 15'd31580;
            7'd54: quarter_lut = 15'd31785; 7'd55: quarter_lut = 15'd31971;
            7'd56: quarter_lut = 15'd32137; 7'd57: quarter_lut = 15'd32285;
            7'd58: quarter_lut = 15'd32412; 7'd59: quarter_lut = 15'd32521;
            7'd60: quarter_lut = 15'd32609; 7'd61: quarter_lut = 15'd32678;
            7'd62: quarter_lut = 15'd32728; 7'd63: quarter_lut = 15'd32757;
            7'd64: quarter_lut = 15'd32767;
            default: quarter_lut = 15'd0;
        endcase
    endfunction

    // Odd quadrants mirror the index, the upper half negates the magnitude.
    function automatic logic signed [15:0] sine_sample(input logic [7:0] p);
        logic [6:0]  idx;
        logic [15:0] mag;
        idx = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
        mag = {1'b0, quarter_lut(idx)};
        sine_sample = p[7] ? -$signed(mag) : $signed(mag);
    endfunction

    assign count_nxt = count_q + COUNT_WIDTH'(1);
    assign sample    = mode_q ? const_q
                              : DATA_WIDTH'(sine_sample(phase_q[PHASE_WIDTH-1 -: 8]));

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        count_d   = count_q;
        x_out_d   = x_out_q;
        x_valid_d = 1'b0;
        mode_d    = mode_q;
        inc_d     = inc_q;
        num_d     = num_q;
        const_d   = const_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    inc_d   = phase_inc;
                    num_d   = num_samples;
                    const_d = const_val;
                    phase_d = '0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // stop wins over a coincident ce
                if (stop) begin
                    state_d = IDLE;
                end else if (ce) begin
                    x_out_d   = sample;
                    x_valid_d = 1'b1;
                    phase_d   = phase_q + inc_q;
                    count_d   = count_nxt;
                    if ((num_q != '0) && (count_nxt == num_q)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            count_q   <= '0;
            x_out_q   <= '0;
            x_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            count_q   <= count_d;
            x_out_q   <= x_out_d;
            x_valid_q <= x_valid_d;
        end
    end

    // Burst configuration only matters while busy; it needs no reset value.
    always_ff @(posedge clk) begin
        mode_q  <= mode_d;
        inc_q   <= inc_d;
        num_q   <= num_d;
        const_q <= const_d;
    end

    assign x_out   = x_out_q;
    assign x_valid = x_valid_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_sine_sample_source.sv
// Bench for sine_sample_source: directed scenarios plus a random run, all
// checked cycle by cycle against a burst-level reference model.
module tb_sine_sample_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start, stop, ce, mode;
    logic [15:0]        phase_inc, num_samples;
    logic signed [15:0] const_val;
    logic signed [15:0] x_out;
    logic               x_valid, busy, done;

    sine_sample_source #(
        .DATA_WIDTH(16), .PHASE_WIDTH(16), .COUNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .ce(ce), .mode(mode),
        .phase_inc(phase_inc), .num_samples(num_samples), .const_val(const_val),
        .x_out(x_out), .x_valid(x_valid), .busy(busy), .done(done)
    );

    int checks   = 0;
    int failures = 0;
    int tick_no  = 0;

    // Reference model state: burst active, finishing cycle, accumulators, latched config.
    bit m_run = 0, m_fin = 0, m_mode = 0;
    int m_phase = 0, m_count = 0, m_inc = 0, m_num = 0, m_const = 0;
    logic signed [15:0] e_xout;
    logic e_valid, e_done, e_busy;

    function automatic int ref_sine(input int ph);
        real r;
        r = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(ph >> 8) / 256.0);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(0.5 - r);
    endfunction

    task automatic model_edge();
        e_valid = 1'b0;
        if (rst) begin
            m_run = 0; m_fin = 0; m_phase = 0; m_count = 0; e_xout = '0;
        end else if (m_fin) begin
            m_fin = 0;
        end else if (m_run) begin
            if (stop) begin
                m_run = 0;
            end else if (ce) begin
                e_xout  = m_mode ? 16'(m_const) : 16'(ref_sine(m_phase));
                e_valid = 1'b1;
                m_phase = (m_phase + m_inc) & 32'hFFFF;
                m_count = (m_count + 1) & 32'hFFFF;
                if (m_num != 0 && m_count == m_num) begin
                    m_run = 0; m_fin = 1;
                end
            end
        end else if (start) begin
            m_mode = mode; m_inc = int'(phase_inc); m_num = int'(num_samples);
            m_const = int'(const_val); m_phase = 0; m_count = 0; m_run = 1;
        end
        e_done = m_fin;
        e_busy = m_run | m_fin;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        tick_no++;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; ce = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        mode = 0; phase_inc = 16'h0; num_samples = 16'h0; const_val = 16'sh0;
        repeat (2) tick();
        checks++;
        if ({x_out, x_valid, done, busy} !== 19'h0) begin
            failures++;
            $display("FAIL reset_state x_out=%0d valid=%b done=%b busy=%b expected all zero", x_out, x_valid, done, busy);
        end
        rst = 0;
        tick();
        checks++;
        if ({x_out, x_valid, done, busy} !== {e_xout, e_valid, e_done, e_busy}) begin
            failures++;
            $display("FAIL reset_release t=%0d x_out=%0d v=%b d=%b b=%b expected x_out=%0d v=%b d=%b b=%b", tick_no, x_out, x_valid, done, busy, e_xout, e_valid, e_done, e_busy);
        end
    endtask

    task automatic test_sine_steps();
        int exp_seq[8] = '{0, 32767, 0, -32767, 0, 32767, 0, -32767};
        int got[$];
        int first_v = -1;
        int n = 0;
        bit done_on_last = 0;
        start = 1; ce = 1; mode = 0; phase_inc = 16'h4000; num_samples = 16'd8;
        for (int i = 0; i < 30; i++) begin
            tick(); start = 0; n++;
            checks++;
            if ({x_out, x_valid, done, busy} !== {e_xout, e_valid, e_done, e_busy}) begin
                failures++;
                $display("FAIL sine_steps t=%0d x_out=%0d v=%b d=%b b=%b expected x_out=%0d v=%b d=%b b=%b", tick_no, x_out, x_valid, done, busy, e_xout, e_valid, e_done, e_busy);
            end
            if (x_valid === 1'b1) begin
                got.push_back(int'(x_out));
                if (first_v < 0) first_v = n;
                if (got.size() == 8) done_on_last = (done === 1'b1);
            end
            if (!e_busy) break;
        end
        ce = 0;
        checks++;
        if (got.size() != 8) begin
            failures++;
            $display("FAIL sine_steps_count got %0d samples expected 8", got.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (got[k] != exp_seq[k]) begin
                    failures++;
                    $display("FAIL sine_steps_value[%0d] got %0d expected %0d", k, got[k], exp_seq[k]);
                end
            end
        end
        checks++;
        if (!done_on_last) begin
            failures++;
            $display("FAIL sine_steps_done got done=0 with last sample expected done=1");
        end
        checks++;
        if (first_v < 2) begin
            failures++;
            $display("FAIL start_with_ce first sample at %0d cycles expected >= 2", first_v);
        end
    endtask

    task automatic test_octant_gating();
        int exp_seq[3] = '{0, 23170, 32767};
        int got[$];
        start = 1; ce = 0; mode = 0; phase_inc = 16'h2000; num_samples = 16'd3;
        tick(); start = 0;
        for (int i = 0; i < 20; i++) begin
            ce = (i % 2 == 0);
            tick();
            checks++;
            if ({x_out, x_valid, done, busy} !== {e_xout, e_valid, e_done, e_busy}) begin
                failures++;
                $display("FAIL octant t=%0d x_out=%0d v=%b d=%b b=%b expected x_out=%0d v=%b d=%b b=%b", tick_no, x_out, x_valid, done, busy, e_xout, e_valid, e_done, e_busy);
            end
            if (x_valid === 1'b1) got.push_back(int'(x_out));
            if (!e_busy) break;
        end
        ce = 0;
        checks++;
        if (got.size() != 3) begin
            failures++;
            $display("FAIL octant_count got %0d samples expected 3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (got[k] != exp_seq[k]) begin
                    failures++;
                    $display("FAIL octant_value[%0d] got %0d expected %0d", k, got[k], exp_seq[k]);
                end
            end
        end
    endtask

    task automatic test_constant();
        int nvals = 0;
        int bad = 0;
        start = 1; ce = 1; mode = 1; const_val = 16'hFFFF; phase_inc = 16'h1234; num_samples = 16'd4;
        tick(); start = 0; mode = 0; const_val = 16'sh0123;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({x_out, x_valid, done, busy} !== {e_xout, e_valid, e_done, e_busy}) begin
                failures++;
                $display("FAIL constant t=%0d x_out=%0d v=%b d=%b b=%b expected x_out=%0d v=%b d=%b b=%b", tick_no, x_out, x_valid, done, busy, e_xout, e_valid, e_done, e_busy);
            end
            if (x_valid === 1'b1) begin
                nvals++;
                if (x_out !== -16'sd1) bad++;
            end
            if (!e_busy) break;
        end
        ce = 0;
        checks++;
        if (nvals != 4 || bad != 0) begin
            failures++;
            $display("FAIL constant_burst got %0d samples (%0d not -1) expected 4 samples of -1", nvals, bad);
        end
    endtask

    task automatic test_continuous_abort();
        int nvals = 0;
        int ndone = 0;
        start = 1; ce = 0; mode = 0; phase_inc = 16'h0CCD; num_samples = 16'd0;
        tick(); start = 0; ce = 1;
        for (int i = 0; i < 101; i++) begin
            if (i == 100) stop = 1;
            tick();
            checks++;
            if ({x_out, x_valid, done, busy} !== {e_xout, e_valid, e_done, e_busy}) begin
                failures++;
                $display("FAIL continuous t=%0d x_out=%0d v=%b d=%b b=%b expected x_out=%0d v=%b d=%b b=%b", tick_no, x_out, x_valid, done, busy, e_xout, e_valid, e_done, e_busy);
            end
            if (x_valid === 1'b1) nvals++;
            if (done !== 1'b0) ndone++;
        end
        stop = 0; ce = 0;
        checks++;
        if (nvals != 100 || ndone != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort samples=%0d done_cycles=%0d busy=%b expected samples=100 done_cycles=0 busy=0", nvals, ndone, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1; ce = 1; mode = 0; phase_inc = 16'h1000; num_samples = 16'd10;
        tick(); start = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin start = 1; phase_inc = 16'h7777; mode = 1; num_samples = 16'd1; end
            tick(); start = 0;
            checks++;
            if ({x_out, x_valid, done, busy} !== {e_xout, e_valid, e_done, e_busy}) begin
                failures++;
                $display("FAIL start_in_run t=%0d x_out=%0d v=%b d=%b b=%b expected x_out=%0d v=%b d=%b b=%b", tick_no, x_out, x_valid, done, busy, e_xout, e_valid, e_done, e_busy);
            end
        end
        rst = 1; start = 1; ce = 1; stop = 1;
        tick();
        checks++;
        if ({x_out, x_valid, done, busy} !== 19'h0) begin
            failures++;
            $display("FAIL reset_mid_run x_out=%0d valid=%b done=%b busy=%b expected all zero", x_out, x_valid, done, busy);
        end
        rst = 0; idle_inputs();
        tick();
        checks++;
        if ({x_out, x_valid, done, busy} !== {e_xout, e_valid, e_done, e_busy}) begin
            failures++;
            $display("FAIL after_reset t=%0d x_out=%0d v=%b d=%b b=%b expected x_out=%0d v=%b d=%b b=%b", tick_no, x_out, x_valid, done, busy, e_xout, e_valid, e_done, e_busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 249) == 0);
            start       = ($urandom_range(0, 5) == 0);
            stop        = ($urandom_range(0, 24) == 0);
            ce          = ($urandom_range(0, 3) != 0);
            mode        = 1'($urandom_range(0, 1));
            phase_inc   = 16'($urandom);
            num_samples = 16'($urandom_range(0, 12));
            const_val   = 16'($urandom);
            tick();
            checks++;
            if ({x_out, x_valid, done, busy} !== {e_xout, e_valid, e_done, e_busy}) begin
                failures++;
                $display("FAIL random t=%0d x_out=%0d v=%b d=%b b=%b expected x_out=%0d v=%b d=%b b=%b", tick_no, x_out, x_valid, done, busy, e_xout, e_valid, e_done, e_busy);
            end
        end
        rst = 0; idle_inputs();
    endtask

    initial begin
        test_reset();
        test_sine_steps();
        test_octant_gating();
        test_constant();
        test_continuous_abort();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
